// File: rtl/calc_controller.sv
// Calculator sequencer: collects operand A, opcode and operand B, fires one ALU enable, latches the result.
// Optional CALC_CHAIN_EN: op_load in SHOW reuses the result as the next A operand.
module calc_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  operand_in,
  input  logic        load,
  input  logic [1:0]  op_in,
  input  logic        op_load,
  input  logic        equals,
  input  logic        clear,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic        enable_add,
  output logic        enable_sub,
  output logic        enable_mul,
  output logic        enable_div,
  input  logic [8:0]  result_add,
  input  logic [7:0]  result_sub,
  input  logic [15:0] result_mul,
  input  logic [7:0]  result_div,
  input  logic        error,
  output logic [15:0] result_out,
  output logic        result_valid,
  output logic        error_out,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e      state_q;
  logic [7:0]  a_q, b_q;
  logic [1:0]  op_q;
  logic        b_loaded_q;
  logic [15:0] result_q;
  logic        valid_q, err_out_q;
  logic [3:0]  en_q;          // {div, mul, sub, add}
  logic [15:0] capture_d;
  logic        ev_equals, ev_op, ev_load;

  // Only the highest-priority event below clear is honoured; lower ones are dropped.
  always_comb begin
    ev_equals = equals;
    ev_op     = op_load & ~equals;
    ev_load   = load & ~op_load & ~equals;
  end

  always_comb begin
    capture_d = '0;
    case (op_q)
      2'd0: capture_d = {7'b0, result_add};
      2'd1: capture_d = {8'b0, result_sub};
      2'd2: capture_d = result_mul;
      2'd3: capture_d = {8'b0, result_div};
      default: capture_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      b_loaded_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      err_out_q  <= 1'b0;
      en_q       <= '0;
    end else begin
      en_q <= '0;
      if (clear) begin
        state_q    <= S_IDLE;
        a_q        <= '0;
        b_q        <= '0;
        op_q       <= '0;
        b_loaded_q <= 1'b0;
        result_q   <= '0;
        valid_q    <= 1'b0;
        err_out_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ev_load) begin
              a_q     <= operand_in;
              state_q <= S_OP;
            end
          end
          S_OP: begin
            if (ev_op) begin
              op_q       <= op_in;
              b_loaded_q <= 1'b0;
              state_q    <= S_B;
            end else if (ev_load) begin
              a_q <= operand_in;
            end
          end
          S_B: begin
            if (ev_equals) begin
              if (b_loaded_q) begin
                state_q <= S_EXEC;
                en_q    <= 4'd1 << op_q;
              end
            end else if (ev_op) begin
              op_q <= op_in;
            end else if (ev_load) begin
              b_q        <= operand_in;
              b_loaded_q <= 1'b1;
            end
          end
          S_EXEC: begin
            if (error) begin
              result_q  <= '0;
              err_out_q <= 1'b1;
              state_q   <= S_ERR;
            end else begin
              result_q <= capture_d;
              valid_q  <= 1'b1;
              state_q  <= S_SHOW;
            end
          end
          S_SHOW: begin
`ifdef CALC_CHAIN_EN
            if (ev_op) begin
              valid_q <= 1'b0;
              if (result_q[15:8] == '0) begin
                a_q        <= result_q[7:0];
                op_q       <= op_in;
                b_loaded_q <= 1'b0;
                state_q    <= S_B;
              end else begin
                result_q  <= '0;
                err_out_q <= 1'b1;
                state_q   <= S_ERR;
              end
            end else
`endif
            if (ev_load) begin
              a_q     <= operand_in;
              b_q     <= '0;
              valid_q <= 1'b0;
              state_q <= S_OP;
            end
          end
          S_ERR: begin
          end
          default: begin
            valid_q   <= 1'b0;
            err_out_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign A            = a_q;
  assign B            = b_q;
  assign enable_add   = en_q[0];
  assign enable_sub   = en_q[1];
  assign enable_mul   = en_q[2];
  assign enable_div   = en_q[3];
  assign result_out   = result_q;
  assign result_valid = valid_q;
  assign error_out    = err_out_q;
  assign state        = state_q;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: a bench-side ALU, an arithmetic reference model
// compared every cycle, and literal spot checks on the headline scenarios.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        rst, load, op_load, equals, clear;
  logic [7:0]  operand_in;
  logic [1:0]  op_in;
  logic [7:0]  A, B;
  logic        enable_add, enable_sub, enable_mul, enable_div;
  logic [8:0]  result_add;
  logic [7:0]  result_sub, result_div;
  logic [15:0] result_mul, result_out;
  logic        alu_err, result_valid, error_out;
  logic [2:0]  state;
  logic [3:0]  en_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_controller dut (
    .clk(clk), .rst(rst), .operand_in(operand_in), .load(load), .op_in(op_in),
    .op_load(op_load), .equals(equals), .clear(clear), .A(A), .B(B),
    .enable_add(enable_add), .enable_sub(enable_sub), .enable_mul(enable_mul),
    .enable_div(enable_div), .result_add(result_add), .result_sub(result_sub),
    .result_mul(result_mul), .result_div(result_div), .error(alu_err),
    .result_out(result_out), .result_valid(result_valid), .error_out(error_out),
    .state(state)
  );

  assign en_vec = {enable_div, enable_mul, enable_sub, enable_add};

  // Bench ALU
  always_comb begin
    result_add = {1'b0, A} + {1'b0, B};
    result_sub = A - B;
    result_mul = 16'(A) * 16'(B);
    result_div = (B == 8'd0) ? 8'd0 : A / B;
    alu_err    = (enable_sub && (A < B)) || (enable_div && (B == 8'd0));
  end

  // Reference model: state index, operands and arithmetic result
  int          mst = 0;
  int          mA = 0, mB = 0, mop = 0, mres = 0;
  bit          mbl = 0;

  always @(posedge clk) begin
    if (rst) begin
      mst = 0; mA = 0; mB = 0; mop = 0; mres = 0; mbl = 0;
    end else if (clear) begin
      mst = 0; mA = 0; mB = 0; mop = 0; mres = 0; mbl = 0;
    end else begin
      case (mst)
        0: if (!equals && !op_load && load) begin mA = operand_in; mst = 1; end
        1: if (!equals) begin
             if (op_load) begin mop = op_in; mbl = 0; mst = 2; end
             else if (load) mA = operand_in;
           end
        2: if (equals) begin
             if (mbl) mst = 3;
           end else if (op_load) mop = op_in;
           else if (load) begin mB = operand_in; mbl = 1; end
        3: begin
             bit e;
             int r;
             e = 0;
             case (mop)
               0: r = mA + mB;
               1: begin e = (mA < mB); r = (mA - mB) & 255; end
               2: r = mA * mB;
               default: begin e = (mB == 0); r = e ? 0 : mA / mB; end
             endcase
             if (e) begin mres = 0; mst = 5; end
             else begin mres = r; mst = 4; end
           end
        4: if (!equals) begin
             if (op_load) begin
`ifdef CALC_CHAIN_EN
               if (mres < 256) begin mA = mres; mop = op_in; mbl = 0; mst = 2; end
               else begin mres = 0; mst = 5; end
`endif
             end else if (load) begin mA = operand_in; mB = 0; mst = 1; end
           end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_state", 32'(state), mst);
    chk("m_A", 32'(A), mA);
    chk("m_B", 32'(B), mB);
    chk("m_result", 32'(result_out), mres);
    chk("m_valid", 32'(result_valid), 32'(mst == 4));
    chk("m_error_out", 32'(error_out), 32'(mst == 5));
    chk("m_enables", 32'(en_vec), (mst == 3) ? (1 << mop) : 0);
  end

  task automatic drive(input bit l, input logic [7:0] v, input bit ol, input logic [1:0] o,
                       input bit eq, input bit cl, input bit r);
    load = l; operand_in = v; op_load = ol; op_in = o; equals = eq; clear = cl; rst = r;
    @(negedge clk);
    load = 0; op_load = 0; equals = 0; clear = 0; rst = 0;
  endtask

  task automatic idle();         drive(0, 8'd0, 0, 2'd0, 0, 0, 0); endtask
  task automatic ld(input logic [7:0] v);  drive(1, v, 0, 2'd0, 0, 0, 0); endtask
  task automatic opl(input logic [1:0] o); drive(0, 8'd0, 1, o, 0, 0, 0); endtask
  task automatic eq();           drive(0, 8'd0, 0, 2'd0, 1, 0, 0); endtask
  task automatic clr();          drive(0, 8'd0, 0, 2'd0, 0, 1, 0); endtask

  int va[8]  = '{25, 200,   9,   200, 200,   5, 9, 255};
  int vop[8] = '{ 0,   0,   1,     2,   3,   1, 3,   2};
  int vb[8]  = '{17, 100,   5,   200,   7,   9, 0, 255};
  int vr[8]  = '{42, 300,   4, 40000,  28,   0, 0, 65025};
  int vs[8]  = '{ 4,   4,   4,     4,   4,   5, 5,   4};

  initial begin
    rst = 1; load = 0; op_load = 0; equals = 0; clear = 0; operand_in = 0; op_in = 0;
    drive(1, 8'd77, 1, 2'd2, 1, 1, 1);
    drive(0, 8'd0, 0, 2'd0, 0, 0, 1);
    chk("rst_state", 32'(state), 0);
    chk("rst_result", 32'(result_out), 0);
    chk("rst_flags", {29'd0, result_valid, error_out, |en_vec}, 0);
    chk("rst_AB", {16'd0, A, B}, 0);

    for (int i = 0; i < 8; i++) begin
      clr();
      ld(8'(va[i])); opl(2'(vop[i])); ld(8'(vb[i])); eq();
      chk("exec_state", 32'(state), 3);
      chk("exec_en", 32'(en_vec), 1 << vop[i]);
      idle();
      chk("vec_result", 32'(result_out), vr[i]);
      chk("vec_state", 32'(state), vs[i]);
      chk("vec_en_low", 32'(en_vec), 0);
    end

    // error path: load ignored in ERR, clear exits
    clr(); ld(8'd5); opl(2'd1); ld(8'd9); eq(); idle();
    chk("err_state", 32'(state), 5);
    chk("err_flag", 32'(error_out), 1);
    chk("err_result", 32'(result_out), 0);
    ld(8'd7); opl(2'd0); eq();
    chk("err_hold", 32'(state), 5);
    clr();
    chk("err_clear_state", 32'(state), 0);
    chk("err_clear_flag", 32'(error_out), 0);

    // divide by zero then reset with every other input asserted
    ld(8'd9); opl(2'd3); ld(8'd0); eq(); idle();
    chk("div0_state", 32'(state), 5);
    drive(1, 8'd33, 1, 2'd1, 1, 1, 1);
    chk("rst2_all", {4'd0, result_out, 3'd0, state, 3'd0, result_valid, error_out, en_vec}, 0);
    chk("rst2_AB", {16'd0, A, B}, 0);

    // equals without B ignored; clear beats equals
    ld(8'd4); opl(2'd0); eq();
    chk("nob_state", 32'(state), 2);
    chk("nob_en", 32'(en_vec), 0);
    ld(8'd6);
    drive(0, 8'd0, 0, 2'd0, 1, 1, 0);
    chk("clreq_state", 32'(state), 0);
    chk("clreq_en", 32'(en_vec), 0);
    idle();

    // clear during EXEC discards the capture
    ld(8'd10); opl(2'd0); ld(8'd20); eq();
    clr();
    chk("clrexec_state", 32'(state), 0);
    chk("clrexec_result", 32'(result_out), 0);

    // priority: equals over load in IDLE, op_load over load, equals over load in B
    drive(1, 8'd50, 0, 2'd0, 1, 0, 0);
    chk("pri_idle", 32'(state), 0);
    ld(8'd50);
    drive(1, 8'd60, 1, 2'd2, 0, 0, 0);
    chk("pri_op_state", 32'(state), 2);
    chk("pri_op_A", 32'(A), 50);
    ld(8'd3);
    drive(1, 8'd99, 0, 2'd0, 1, 0, 0);
    idle();
    chk("pri_eq_result", 32'(result_out), 150);
    ld(8'd7);
    chk("show_load", {24'd0, 1'b0, state, A}, {24'd0, 4'd1, 8'd7});
    chk("show_load_B", 32'(B), 0);

    // op_load in SHOW with a wide result
    clr(); ld(8'd200); opl(2'd2); ld(8'd200); eq(); idle();
    opl(2'd0);
`ifdef CALC_CHAIN_EN
    chk("wide_chain_state", 32'(state), 5);
`else
    chk("wide_chain_state", 32'(state), 4);
    chk("wide_chain_result", 32'(result_out), 40000);
`endif

    // chaining 10+5 then *3
    clr(); ld(8'd10); opl(2'd0); ld(8'd5); eq(); idle();
    chk("chain_first", 32'(result_out), 15);
    opl(2'd2);
`ifdef CALC_CHAIN_EN
    ld(8'd3); eq(); idle();
    chk("chain_result", 32'(result_out), 45);
    chk("chain_state", 32'(state), 4);
`else
    chk("nochain_state", 32'(state), 4);
    chk("nochain_result", 32'(result_out), 15);
`endif
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
